// File: rtl/nn_layer_sequencer_if.sv
// Bundles the sequencer's control/status signals toward the input buffer,
// weight ROM, shared MAC and result register file.
//   master : sequencer side (drives strobes/addresses, receives start)
//   slave  : controller/datapath side (drives start, observes the rest)
// Signals: start, busy, done, rd_en, in_addr, w_addr, mac_clr, mac_en,
//          mac_last, out_we, out_addr.
interface nn_layer_sequencer_if #(
  parameter int unsigned N_IN  = 208,
  parameter int unsigned N_OUT = 15
);
  localparam int unsigned InW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WW   = ($clog2(N_IN * N_OUT) > 0) ? $clog2(N_IN * N_OUT) : 1;
  localparam int unsigned OutW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [InW-1:0]  in_addr;
  logic [WW-1:0]   w_addr;
  logic            mac_clr;
  logic            mac_en;
  logic            mac_last;
  logic            out_we;
  logic [OutW-1:0] out_addr;

  modport master (
    input  start,
    output busy, done, rd_en, in_addr, w_addr, mac_clr, mac_en, mac_last, out_we, out_addr
  );

  modport slave (
    output start,
    input  busy, done, rd_en, in_addr, w_addr, mac_clr, mac_en, mac_last, out_we, out_addr
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer pass over a single shared MAC.
// Per neuron: CLEAR (load bias) -> N_IN reads in ACCUM -> DRAIN (last MAC
// accumulate) -> WRITE (store result), i.e. N_IN+3 cycles, then DONE.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : nn_layer_sequencer_if master modport (start in; strobes,
//          addresses and status out). All outputs are registered.
module nn_layer_sequencer #(
  parameter int unsigned N_IN  = 208,
  parameter int unsigned N_OUT = 15
) (
  input logic                  clk,
  input logic                  rst,
  nn_layer_sequencer_if.master bus
);
  localparam int unsigned InW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WW   = ($clog2(N_IN * N_OUT) > 0) ? $clog2(N_IN * N_OUT) : 1;
  localparam int unsigned OutW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [InW-1:0]  ILast = InW'(N_IN - 1);
  localparam logic [OutW-1:0] NLast = OutW'(N_OUT - 1);

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StWrite, StDone} state_e;

  state_e          state_q;
  logic [OutW-1:0] n_q;
  logic [InW-1:0]  i_q;
  logic [WW-1:0]   w_q;

  logic            busy_q, done_q, rd_en_q, mac_clr_q, mac_en_q, mac_last_q, out_we_q;
  logic [InW-1:0]  in_addr_q;
  logic [WW-1:0]   w_addr_q;
  logic [OutW-1:0] out_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      i_q        <= '0;
      w_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_last_q <= 1'b0;
      out_we_q   <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
    end else begin
      // Read data has one cycle of latency, so the MAC strobes trail rd_en.
      // While rd_en_q is high we are in ACCUM and i_q is the index being read.
      mac_en_q   <= rd_en_q;
      mac_last_q <= rd_en_q && (i_q == ILast);

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StClear;
            busy_q     <= 1'b1;
            mac_clr_q  <= 1'b1;
            n_q        <= '0;
            i_q        <= '0;
            w_q        <= '0;
            out_addr_q <= '0;
          end
        end
        StClear: begin
          state_q   <= StAccum;
          mac_clr_q <= 1'b0;
          rd_en_q   <= 1'b1;
          in_addr_q <= i_q;
          w_addr_q  <= w_q;
        end
        StAccum: begin
          // w runs across neurons, so it always equals n*N_IN+i.
          w_q <= w_q + 1'b1;
          if (i_q == ILast) begin
            i_q     <= '0;
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            i_q       <= i_q + 1'b1;
            in_addr_q <= i_q + 1'b1;
            w_addr_q  <= w_q + 1'b1;
          end
        end
        StDrain: begin
          state_q  <= StWrite;
          out_we_q <= 1'b1;
        end
        StWrite: begin
          out_we_q <= 1'b0;
          if (n_q == NLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            n_q        <= n_q + 1'b1;
            out_addr_q <= n_q + 1'b1;
            state_q    <= StClear;
            mac_clr_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.mac_clr  = mac_clr_q;
  assign bus.mac_en   = mac_en_q;
  assign bus.mac_last = mac_last_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: a small instance (N_IN=4, N_OUT=3) for detailed cycle
// timing and a default instance (208, 15) for the full-size pass.
// Cycle c is the clock period between edge c-1 and edge c; inputs driven in
// cycle c are sampled at edge c; outputs are sampled 1 time unit after edge c-1.
module tb_nn_layer_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  nn_layer_sequencer_if #(.N_IN(4),   .N_OUT(3))  if_s ();
  nn_layer_sequencer_if #(.N_IN(208), .N_OUT(15)) if_d ();

  nn_layer_sequencer #(.N_IN(4), .N_OUT(3)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (if_s.master)
  );

  nn_layer_sequencer #(.N_IN(208), .N_OUT(15)) u_dflt (
    .clk (clk),
    .rst (rst),
    .bus (if_d.master)
  );

  task automatic test_reset();
    rst = 1'b1;
    if_s.start = 1'b0;
    if_d.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_s.busy, if_s.done, if_s.mac_clr, if_s.rd_en, if_s.mac_en, if_s.mac_last,
         if_s.out_we, if_s.in_addr, if_s.w_addr, if_s.out_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_small: got busy=%b done=%b clr=%b rd=%b en=%b last=%b we=%b, want all 0",
               if_s.busy, if_s.done, if_s.mac_clr, if_s.rd_en, if_s.mac_en, if_s.mac_last,
               if_s.out_we);
    end
    vectors++;
    if ({if_d.busy, if_d.done, if_d.mac_clr, if_d.rd_en, if_d.mac_en, if_d.mac_last,
         if_d.out_we, if_d.in_addr, if_d.w_addr, if_d.out_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_default: got busy=%b done=%b rd=%b w_addr=%0d, want all 0",
               if_d.busy, if_d.done, if_d.rd_en, if_d.w_addr);
    end
    rst = 1'b0;
  endtask

  // One pass on the small instance with cycle-exact expectations.
  // extra_starts: pulse start in cycles 5 and 22 (must be ignored).
  // rst_cycle: if nonzero, assert rst in that cycle and check zeros next cycle.
  task automatic test_pass(input bit extra_starts, input int rst_cycle);
    logic [6:0] got, exp;
    logic [1:0] exp_in;
    logic [3:0] exp_w;
    int k, p, dones;
    dones = 0;
    @(posedge clk);
    #1;
    if_s.start = 1'b1;  // cycle 0
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk);
      #1;
      if (rst_cycle != 0 && c == rst_cycle + 1) begin
        vectors++;
        if ({if_s.busy, if_s.done, if_s.mac_clr, if_s.rd_en, if_s.mac_en, if_s.mac_last,
             if_s.out_we, if_s.in_addr, if_s.w_addr, if_s.out_addr} !== '0) begin
          miscompares++;
          $display("FAIL mid_pass_reset c=%0d: got busy=%b rd=%b en=%b in=%0d w=%0d, want all 0",
                   c, if_s.busy, if_s.rd_en, if_s.mac_en, if_s.in_addr, if_s.w_addr);
        end
        rst = 1'b0;
        if_s.start = 1'b0;
        break;
      end
      k = (c - 1) / 7;
      p = (c - 1) % 7;
      exp = '0;
      if (c <= 21) begin
        exp[6] = 1'b1;
        exp[4] = (p == 0);
        exp[3] = (p >= 1 && p <= 4);
        exp[2] = (p >= 2 && p <= 5);
        exp[1] = (p == 5);
        exp[0] = (p == 6);
      end else if (c == 22) begin
        exp = 7'b1100000;
      end
      got = {if_s.busy, if_s.done, if_s.mac_clr, if_s.rd_en, if_s.mac_en, if_s.mac_last,
             if_s.out_we};
      if (if_s.done) dones++;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL strobes c=%0d: got {busy,done,clr,rd,en,last,we}=%b, want %b",
                 c, got, exp);
      end
      // Addresses: live during reads, held at their last values otherwise.
      if (c >= 2) begin
        if (c <= 21 && p >= 1 && p <= 4) begin
          exp_in = 2'(p - 1);
          exp_w  = 4'(k * 4 + p - 1);
        end else if (c <= 21 && p == 0) begin
          exp_in = 2'd3;
          exp_w  = 4'(k * 4 - 1);
        end else if (c <= 21) begin
          exp_in = 2'd3;
          exp_w  = 4'(k * 4 + 3);
        end else begin
          exp_in = 2'd3;
          exp_w  = 4'd11;
        end
        vectors++;
        if (if_s.in_addr !== exp_in || if_s.w_addr !== exp_w) begin
          miscompares++;
          $display("FAIL addr c=%0d: got in_addr=%0d w_addr=%0d, want %0d %0d",
                   c, if_s.in_addr, if_s.w_addr, exp_in, exp_w);
        end
      end
      if (exp[0]) begin
        vectors++;
        if (if_s.out_addr !== 2'(k)) begin
          miscompares++;
          $display("FAIL out_addr c=%0d: got %0d, want %0d", c, if_s.out_addr, k);
        end
      end
      vectors++;
      if ((int'(if_s.mac_clr) + int'(if_s.rd_en | if_s.mac_en) + int'(if_s.out_we)) > 1 ||
          (if_s.mac_last && !if_s.mac_en)) begin
        miscompares++;
        $display("FAIL exclusive c=%0d: got clr=%b rd=%b en=%b last=%b we=%b, want at most one",
                 c, if_s.mac_clr, if_s.rd_en, if_s.mac_en, if_s.mac_last, if_s.out_we);
      end
      // Inputs for this cycle.
      if_s.start = extra_starts && (c == 5 || c == 22);
      rst = (c == rst_cycle);
    end
    if_s.start = 1'b0;
    if (rst_cycle == 0) begin
      vectors++;
      if (dones !== 1) begin
        miscompares++;
        $display("FAIL done_count: got %0d done pulses, want 1", dones);
      end
    end
  endtask

  task automatic test_mid_pass_reset();
    test_pass(1'b0, 10);
    test_pass(1'b0, 0);
  endtask

  task automatic test_reset_priority();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_s.start = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (if_s.busy !== 1'b0 || if_s.mac_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority: got busy=%b mac_clr=%b, want 0 0", if_s.busy, if_s.mac_clr);
    end
    rst = 1'b0;
    if_s.start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (if_s.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority_after: got busy=%b, want 0", if_s.busy);
    end
  endtask

  task automatic test_default_held();
    int first_done, dones, last_w, clr2, busy_gaps;
    logic first_clr;
    first_done = -1;
    dones      = 0;
    last_w     = -1;
    clr2       = -1;
    busy_gaps  = 0;
    first_clr  = 1'b0;
    @(posedge clk);
    #1;
    if_d.start = 1'b1;  // cycle 0, held high throughout
    for (int c = 1; c <= 3175; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) first_clr = if_d.mac_clr;
      if (if_d.done) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (first_done < 0 && if_d.rd_en) last_w = int'(if_d.w_addr);
      if (first_done < 0 && !if_d.busy) busy_gaps++;
      if (first_done >= 0 && clr2 < 0 && if_d.mac_clr) clr2 = c;
    end
    if_d.start = 1'b0;
    vectors++;
    if (first_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL dflt_first_clr: got mac_clr=%b in cycle 1, want 1", first_clr);
    end
    vectors++;
    if (first_done != 3166) begin
      miscompares++;
      $display("FAIL dflt_done_cycle: got %0d, want 3166", first_done);
    end
    vectors++;
    if (last_w != 3119) begin
      miscompares++;
      $display("FAIL dflt_last_w_addr: got %0d, want 3119", last_w);
    end
    vectors++;
    if (clr2 != 3168) begin
      miscompares++;
      $display("FAIL dflt_second_clr: got %0d, want 3168", clr2);
    end
    vectors++;
    if (dones != 1 || busy_gaps != 0) begin
      miscompares++;
      $display("FAIL dflt_done_busy: got dones=%0d busy_gaps=%0d, want 1 0", dones, busy_gaps);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_s.start = 1'b0;
    if_d.start = 1'b0;
    test_reset();
    test_pass(1'b0, 0);
    test_pass(1'b1, 0);
    test_mid_pass_reset();
    test_reset_priority();
    test_default_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
